// File: rtl/display_scan_pkg.sv
// Shared types and constants for the multiplexed display scan capture block.
package display_scan_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    EXP1 = 3'd1,
    EXP2 = 3'd2,
    EXP3 = 3'd3,
    EXP0 = 3'd4
  } state_t;

  // Active-low one-hot digit selects as they appear on the scan lines.
  localparam logic [3:0] DIG0  = 4'b1110;
  localparam logic [3:0] DIG1  = 4'b1101;
  localparam logic [3:0] DIG2  = 4'b1011;
  localparam logic [3:0] DIG3  = 4'b0111;
  localparam logic [3:0] BLANK = 4'b1111;

  localparam int OFF0 = 12;
  localparam int OFF1 = 8;
  localparam int OFF2 = 4;
  localparam int OFF3 = 0;

endpackage

// File: rtl/scan_sync.sv
// Two-flop synchronizer for a bus of asynchronous scan inputs; latency 2 cycles.
// No backpressure: samples every cycle.
module scan_sync #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/display_scan_capture.sv
// Rebuilds a 4-digit word from a scanned display; Frame_valid 2+STABLE_CYCLES edges after digit3.
// No backpressure: the scan is free-running, the block only observes it.
module display_scan_capture
  import display_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [3:0]  Seg_in,
  input  logic [3:0]  Bit_in,
  output logic [15:0] Word,
  output logic        Frame_valid,
  output logic        Word_stable,
  output logic        Err,
  output logic [7:0]  Err_count
);

  localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);

  logic [3:0]  w_seg;
  logic [3:0]  w_bit;
  logic [3:0]  r_bit_prev;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  r_last;
  logic        w_changed;
  logic        w_reach;
  logic        w_accept;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:4] r_shadow;
  logic [15:4] w_shadow_nxt;
  logic [15:0] r_word;
  logic [15:0] w_word_nxt;
  logic        r_fv;
  logic        w_fv_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic        r_ws;
  logic        w_ws_nxt;
  logic [7:0]  r_err_cnt;

  scan_sync #(.WIDTH(4), .RST_VAL(4'h0)) u_seg_sync (
    .i_clk   (CLK),
    .i_rst_n (Reset),
    .i_d     (Seg_in),
    .o_q     (w_seg)
  );

  scan_sync #(.WIDTH(4), .RST_VAL(BLANK)) u_bit_sync (
    .i_clk   (CLK),
    .i_rst_n (Reset),
    .i_d     (Bit_in),
    .o_q     (w_bit)
  );

  assign w_changed = (w_bit != r_bit_prev);

  always_comb begin
    if (w_changed)               w_cnt_nxt = 4'd1;
    else if (r_cnt == LP_STABLE) w_cnt_nxt = r_cnt;
    else                         w_cnt_nxt = r_cnt + 4'd1;
  end

  // Fires only on the cycle the counter arrives at the threshold, not while parked there.
  assign w_reach  = (w_cnt_nxt == LP_STABLE) && (w_changed || (r_cnt != LP_STABLE));
  assign w_accept = w_reach && (w_bit != r_last);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_word_nxt   = r_word;
    w_fv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    w_ws_nxt     = r_ws;
    if (w_accept) begin
      case (w_bit)
        BLANK: w_state_nxt = r_state;
        DIG0: begin
          w_shadow_nxt[OFF0 +: 4] = w_seg;
          w_state_nxt             = EXP1;
          w_err_nxt               = (r_state inside {EXP1, EXP2, EXP3});
        end
        DIG1: begin
          if (r_state == EXP1) begin
            w_shadow_nxt[OFF1 +: 4] = w_seg;
            w_state_nxt             = EXP2;
          end else if (r_state != HUNT) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        DIG2: begin
          if (r_state == EXP2) begin
            w_shadow_nxt[OFF2 +: 4] = w_seg;
            w_state_nxt             = EXP3;
          end else if (r_state != HUNT) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        DIG3: begin
          if (r_state == EXP3) begin
            w_word_nxt              = {r_shadow, 4'h0};
            w_word_nxt[OFF3 +: 4]   = w_seg;
            w_ws_nxt                = (w_word_nxt == r_word);
            w_fv_nxt                = 1'b1;
            w_state_nxt             = EXP0;
          end else if (r_state != HUNT) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        default: begin
          w_err_nxt    = 1'b1;
          w_shadow_nxt = '0;
          w_state_nxt  = HUNT;
        end
      endcase
      if (w_err_nxt) begin
        w_ws_nxt   = 1'b0;
        w_fv_nxt   = 1'b0;
        w_word_nxt = r_word;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_bit_prev <= BLANK;
      r_cnt      <= 4'd0;
      r_last     <= BLANK;
      r_shadow   <= '0;
      r_word     <= '0;
      r_fv       <= 1'b0;
      r_err      <= 1'b0;
      r_ws       <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_bit_prev <= w_bit;
      r_cnt      <= w_cnt_nxt;
      if (w_accept) r_last <= w_bit;
      r_shadow   <= w_shadow_nxt;
      r_word     <= w_word_nxt;
      r_fv       <= w_fv_nxt;
      r_err      <= w_err_nxt;
      r_ws       <= w_ws_nxt;
      if (w_err_nxt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign Word        = r_word;
  assign Frame_valid = r_fv;
  assign Word_stable = r_ws;
  assign Err         = r_err;
  assign Err_count   = r_err_cnt;

endmodule

// File: tb/tb_display_scan_capture.sv
// Directed plus randomized scan sequences checked against a frame-level reference model.
module tb_display_scan_capture;
  import display_scan_pkg::*;

  localparam int STABLE = 2;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [3:0]  Seg_in;
  logic [3:0]  Bit_in;
  logic [15:0] Word;
  logic        Frame_valid;
  logic        Word_stable;
  logic        Err;
  logic [7:0]  Err_count;

  always #5 CLK = ~CLK;

  display_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Seg_in      (Seg_in),
    .Bit_in      (Bit_in),
    .Word        (Word),
    .Frame_valid (Frame_valid),
    .Word_stable (Word_stable),
    .Err         (Err),
    .Err_count   (Err_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int fv_seen = 0;
  int err_seen = 0;
  int fv_cyc = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Frame_valid === 1'b1) begin
      fv_seen++;
      fv_cyc = cyc;
    end
    if (Err === 1'b1) err_seen++;
  end

  // Reference model: acceptance per pin-level run length, then frame ordering rules.
  logic [3:0]  dcode [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0]  m_last;
  logic [3:0]  m_run_code;
  int          m_run;
  int          m_exp;
  logic [3:0]  m_nib [4];
  logic [15:0] m_word;
  logic        m_ws;
  int          m_errcnt;
  int          m_fv  = 0;
  int          m_err = 0;

  function automatic int dig_idx(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c == dcode[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_last     = 4'hF;
    m_run_code = 4'hF;
    m_run      = STABLE;
    m_exp      = -1;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_word     = 16'h0;
    m_ws       = 1'b0;
    m_errcnt   = 0;
  endtask

  task automatic m_error();
    m_err++;
    m_ws = 1'b0;
    if (m_errcnt < 255) m_errcnt++;
  endtask

  task automatic m_accept(input logic [3:0] code, input logic [3:0] nib);
    int d;
    logic [15:0] w;
    if (code == m_last) return;
    m_last = code;
    if (code == 4'hF) return;
    d = dig_idx(code);
    if (d < 0) begin
      m_error();
      m_exp = -1;
    end else if (m_exp == -1) begin
      if (d == 0) begin
        m_nib[0] = nib;
        m_exp = 1;
      end
    end else if (d == m_exp) begin
      m_nib[d] = nib;
      if (d == 3) begin
        w = {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
        m_ws = (w == m_word);
        m_word = w;
        m_fv++;
      end
      m_exp = (d + 1) % 4;
    end else begin
      m_error();
      if (d == 0) begin
        m_nib[0] = nib;
        m_exp = 1;
      end else begin
        m_exp = -1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] code, input logic [3:0] nib, input int n);
    Bit_in = code;
    Seg_in = nib;
    for (int i = 0; i < n; i++) begin
      if (code == m_run_code) m_run++;
      else begin
        m_run_code = code;
        m_run = 1;
      end
      if (m_run == STABLE) m_accept(code, nib);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    hold(dcode[0], w[15:12], n);
    hold(dcode[1], w[11:8],  n);
    hold(dcode[2], w[7:4],   n);
    hold(dcode[3], w[3:0],   n);
  endtask

  task automatic checkpoint(input string tag);
    hold(Bit_in, Seg_in, 4);
    chk({tag, ".word"},   {16'h0, Word},        {16'h0, m_word});
    chk({tag, ".ws"},     {31'h0, Word_stable}, {31'h0, m_ws});
    chk({tag, ".errcnt"}, {24'h0, Err_count},   m_errcnt);
    chk({tag, ".frames"}, fv_seen,              m_fv);
    chk({tag, ".errs"},   err_seen,             m_err);
    chk({tag, ".fvq"},    {31'h0, Frame_valid}, 32'h0);
    chk({tag, ".errq"},   {31'h0, Err},         32'h0);
  endtask

  task automatic do_reset(input string tag);
    #2 Reset = 1'b0;
    #1;
    chk({tag, ".word0"},   {16'h0, Word},        32'h0);
    chk({tag, ".fv0"},     {31'h0, Frame_valid}, 32'h0);
    chk({tag, ".ws0"},     {31'h0, Word_stable}, 32'h0);
    chk({tag, ".err0"},    {31'h0, Err},         32'h0);
    chk({tag, ".errcnt0"}, {24'h0, Err_count},   32'h0);
    Bit_in = 4'hF;
    Seg_in = 4'h0;
    m_reset();
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    hold(4'hF, 4'h0, 3);
  endtask

  initial begin
    logic [3:0] code;
    logic [3:0] nib;
    int n, sel, g, c0, fv0, err0;

    Reset  = 1'b0;
    Bit_in = 4'hF;
    Seg_in = 4'h0;
    m_reset();
    #12;
    chk("rst.word",   {16'h0, Word},        32'h0);
    chk("rst.fv",     {31'h0, Frame_valid}, 32'h0);
    chk("rst.ws",     {31'h0, Word_stable}, 32'h0);
    chk("rst.err",    {31'h0, Err},         32'h0);
    chk("rst.errcnt", {24'h0, Err_count},   32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    hold(4'hF, 4'h0, 3);

    // Basic frame and digit3-to-Frame_valid latency
    fv0  = fv_seen;
    err0 = err_seen;
    hold(dcode[0], 4'h1, 4);
    hold(dcode[1], 4'hA, 4);
    hold(dcode[2], 4'h2, 4);
    c0 = cyc;
    hold(dcode[3], 4'hF, 4);
    checkpoint("f1a2f");
    chk("f1a2f.latency", fv_cyc - c0, STABLE + 2);
    chk("f1a2f.onepulse", fv_seen - fv0, 1);
    chk("f1a2f.noerr", err_seen - err0, 0);
    chk("f1a2f.value", {16'h0, Word}, 32'h1A2F);

    // Word_stable across repeated and changed frames
    frame(16'hBEEF, 3);
    frame(16'hBEEF, 3);
    checkpoint("beef2");
    chk("beef2.ws_hi", {31'h0, Word_stable}, 32'h1);
    frame(16'hBEE0, 3);
    checkpoint("bee0");
    chk("bee0.ws_lo", {31'h0, Word_stable}, 32'h0);

    // Skipped digit2
    hold(dcode[0], 4'h7, 3);
    hold(dcode[1], 4'h7, 3);
    hold(dcode[3], 4'h7, 3);
    checkpoint("skip");
    chk("skip.errcnt1", {24'h0, Err_count}, 32'h1);
    frame(16'h0123, 3);
    checkpoint("f0123");
    chk("f0123.value", {16'h0, Word}, 32'h0123);

    // Held multi-hot code versus a one-cycle glitch
    hold(dcode[0], 4'h3, 3);
    hold(dcode[1], 4'h4, 3);
    hold(4'b1100, 4'h5, 3);
    hold(dcode[2], 4'h6, 3);
    checkpoint("multihot");
    hold(dcode[0], 4'hC, 3);
    hold(4'b1100, 4'h0, 1);
    hold(dcode[1], 4'hD, 3);
    hold(dcode[2], 4'hE, 3);
    hold(dcode[3], 4'h9, 3);
    checkpoint("glitch");
    chk("glitch.value", {16'h0, Word}, 32'hCDE9);

    // Reset in the middle of a frame
    hold(dcode[0], 4'h9, 4);
    hold(dcode[1], 4'h8, 4);
    hold(dcode[2], 4'h7, 4);
    do_reset("midrst");
    hold(dcode[3], 4'h5, 4);
    checkpoint("postrst");
    frame(16'h4567, 4);
    checkpoint("f4567");
    chk("f4567.value", {16'h0, Word}, 32'h4567);

    // Error counter saturation
    err0 = err_seen;
    for (int i = 0; i < 260; i++) begin
      hold(dcode[0], 4'h0, 2);
      hold(dcode[2], 4'h0, 2);
      if (i == 254) checkpoint("sat255");
    end
    checkpoint("sat260");
    chk("sat.errcnt", {24'h0, Err_count}, 32'hFF);
    chk("sat.pulses", err_seen - err0, 260);

    // Randomized scan traffic
    do_reset("rndrst");
    g = 0;
    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(0, 9));
      nib = 4'($urandom_range(0, 15));
      n   = int'($urandom_range(1, 5));
      if (sel <= 5) begin
        code = dcode[g];
        g = (g + 1) % 4;
      end else if (sel == 6) code = dcode[$urandom_range(0, 3)];
      else if (sel == 7)     code = 4'hF;
      else                   code = 4'($urandom_range(0, 15));
      hold(code, nib, n);
      if (k % 30 == 29) checkpoint($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
